// File: rtl/uart_rx_block_assembler.sv
// -----------------------------------------------------------------------------
// uart_rx_block_assembler
//
// Drains a show-ahead UART RX FIFO and packs consecutive bytes into one
// BYTES_PER_BLOCK-byte block for the AES input stage. The block is offered over
// a valid/ready handshake. The first byte received ends up in the MSBs.
//
// Optional feature (compile-time macro RX_TIMEOUT_FLUSH_EN):
//   A partial block is handed out once the FIFO has been idle for
//   TIMEOUT_CYCLES cycles. The bytes are left-aligned and the low bytes are
//   zero-filled. When the macro is undefined, partial blocks wait indefinitely
//   and TIMEOUT_CYCLES has no effect.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   flush      in   synchronous; discards a partially collected block
//   rx_empty   in   RX FIFO empty flag
//   rx_data    in   RX FIFO head word (valid while rx_empty=0)
//   rx_rd      out  RX FIFO pop strobe (combinational)
//   blk_data   out  assembled block, first byte in MSBs
//   blk_count  out  number of valid bytes in blk_data
//   blk_valid  out  block available
//   blk_ready  in   consumer accepts the block
// -----------------------------------------------------------------------------
module uart_rx_block_assembler #(
  parameter int BYTES_PER_BLOCK = 16,
  parameter int DATA_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    flush,
  input  logic                                    rx_empty,
  input  logic [DATA_WIDTH-1:0]                   rx_data,
  output logic                                    rx_rd,
  output logic [BYTES_PER_BLOCK*DATA_WIDTH-1:0]   blk_data,
  output logic [$clog2(BYTES_PER_BLOCK+1)-1:0]    blk_count,
  output logic                                    blk_valid,
  input  logic                                    blk_ready
);

  localparam int W  = BYTES_PER_BLOCK * DATA_WIDTH;
  localparam int CW = $clog2(BYTES_PER_BLOCK + 1);

  // Elaboration-time parameter sanity check
  if (BYTES_PER_BLOCK < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_rx_block_assembler: BYTES_PER_BLOCK and TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          pop_s;
  logic          last_pop_s;

  // Pop decision: only while collecting, never during flush or reset
  always_comb begin
    pop_s      = (state_r == COLLECT) && !rx_empty && !flush && !reset;
    last_pop_s = pop_s && (cnt_r == CW'(BYTES_PER_BLOCK - 1));
  end

  assign rx_rd = pop_s;

`ifdef RX_TIMEOUT_FLUSH_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES);

  logic [IW-1:0] idle_r;
  logic          expire_s;
  logic [W-1:0]  aligned_s;

  // Timeout expiry and left-alignment of the partial block
  always_comb begin
    expire_s  = (state_r == COLLECT) && (cnt_r != {CW{1'b0}}) && !pop_s && !flush &&
                (idle_r == IW'(TIMEOUT_CYCLES - 1));
    aligned_s = blk_data << (DATA_WIDTH * (BYTES_PER_BLOCK - int'(cnt_r)));
  end

  // Idle counter: runs only while a partial block waits for more bytes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_r <= {IW{1'b0}};
    end else if (pop_s || flush || (state_r != COLLECT)) begin
      idle_r <= {IW{1'b0}};
    end else if ((cnt_r != {CW{1'b0}}) && !expire_s) begin
      idle_r <= idle_r + IW'(1'b1);
    end else begin
      idle_r <= idle_r;
    end
  end
`endif

  // Block assembly FSM with registered block outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= COLLECT;
      cnt_r     <= {CW{1'b0}};
      blk_data  <= {W{1'b0}};
      blk_count <= {CW{1'b0}};
      blk_valid <= 1'b0;
    end else begin
      case (state_r)
        COLLECT: begin
          if (flush) begin
            cnt_r    <= {CW{1'b0}};
            blk_data <= {W{1'b0}};
          end else if (pop_s) begin
            blk_data <= {blk_data[W-DATA_WIDTH-1:0], rx_data};
            cnt_r    <= cnt_r + CW'(1'b1);
            if (last_pop_s) begin
              state_r   <= OUTPUT;
              blk_valid <= 1'b1;
              blk_count <= CW'(BYTES_PER_BLOCK);
            end
          end
`ifdef RX_TIMEOUT_FLUSH_EN
          // A pop in the same cycle wins over timeout expiry
          else if (expire_s) begin
            state_r   <= OUTPUT;
            blk_valid <= 1'b1;
            blk_count <= cnt_r;
            blk_data  <= aligned_s;
          end
`endif
        end
        OUTPUT: begin
          // flush is ignored here: a valid block is never retracted
          if (blk_ready) begin
            state_r   <= COLLECT;
            blk_valid <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            blk_data  <= {W{1'b0}};
            blk_count <= {CW{1'b0}};
          end
        end
        default: begin
          state_r   <= COLLECT;
          cnt_r     <= {CW{1'b0}};
          blk_data  <= {W{1'b0}};
          blk_count <= {CW{1'b0}};
          blk_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
